// File: rtl/intr_request_source.sv
// intr_request_source
//
// Initiator side of the three-line external interrupt protocol (IRA/IRB/IRC).
// Three raw push-buttons are synchronised and debounced. Each accepted press
// raises a level-held request that stays up until the CPU returns the matching
// clear number. The CPU must then release the clear number before the channel
// can re-arm (4-phase handshake). Presses that arrive while a channel is busy
// are counted in a per-channel saturating counter.
//
// Ports:
//   clk        board clock
//   rst_n      asynchronous active-low reset
//   btn[2:0]   raw buttons (bit0=A, bit1=B, bit2=C), asynchronous and bouncing
//   clr_no     clear number from CPU (0=none, 1=A, 2=B, 3=C), asynchronous
//   clr_missed synchronous pulse, zeroes all missed counters
//   irq[2:0]   level interrupt requests (bit0=IRA, bit1=IRB, bit2=IRC)
//   missed_a/b/c  saturating counts of presses dropped while busy

module intr_request_source #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn,
    input  logic [1:0] clr_no,
    input  logic       clr_missed,
    output logic [2:0] irq,
    output logic [7:0] missed_a,
    output logic [7:0] missed_b,
    output logic [7:0] missed_c
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizers
    logic [2:0] btn_s1_q, btn_s2_q;
    logic [1:0] clr_s1_q, clr_s2_q, clr_s3_q;
    logic [1:0] ack_q, ack_d;

    // Per-channel state
    logic [CNT_W-1:0] cnt_q     [3];
    logic [CNT_W-1:0] cnt_d     [3];
    logic [2:0]       stable_q, stable_d;
    logic [2:0]       rise_q,   rise_d;
    state_t           state_q   [3];
    state_t           state_d   [3];
    logic [2:0]       irq_q,    irq_d;
    logic [7:0]       missed_q  [3];
    logic [7:0]       missed_d  [3];

    // The ack value only updates when two consecutive synchronized samples
    // agree, so a multi-bit clr_no change that lands skewed across the
    // synchronizer never presents a transient intermediate code.
    always_comb begin
        ack_d = ack_q;
        if (clr_s2_q == clr_s3_q) begin
            ack_d = clr_s2_q;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]    = cnt_q[i];
            stable_d[i] = stable_q[i];
            rise_d[i]   = 1'b0;
            state_d[i]  = state_q[i];
            missed_d[i] = missed_q[i];

            // Debounce: any return to the stable level restarts the count.
            if (btn_s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = btn_s2_q[i];
                cnt_d[i]    = '0;
                rise_d[i]   = btn_s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            // A rise in IDLE wins over a concurrent matching ack.
            unique case (state_q[i])
                IDLE:    if (rise_q[i])               state_d[i] = REQ;
                REQ:     if (ack_q == 2'(i + 1))      state_d[i] = ACKED;
                ACKED:   if (ack_q != 2'(i + 1))      state_d[i] = IDLE;
                default:                              state_d[i] = IDLE;
            endcase

            // Clear has priority over a concurrent increment.
            if (clr_missed) begin
                missed_d[i] = '0;
            end else if (rise_q[i] && (state_q[i] != IDLE) && (missed_q[i] != 8'hFF)) begin
                missed_d[i] = missed_q[i] + 8'd1;
            end

            irq_d[i] = (state_q[i] == REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            clr_s1_q <= '0;
            clr_s2_q <= '0;
            clr_s3_q <= '0;
            ack_q    <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            irq_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]    <= '0;
                state_q[i]  <= IDLE;
                missed_q[i] <= '0;
            end
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            clr_s1_q <= clr_no;
            clr_s2_q <= clr_s1_q;
            clr_s3_q <= clr_s2_q;
            ack_q    <= ack_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            irq_q    <= irq_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]    <= cnt_d[i];
                state_q[i]  <= state_d[i];
                missed_q[i] <= missed_d[i];
            end
        end
    end

    assign irq      = irq_q;
    assign missed_a = missed_q[0];
    assign missed_b = missed_q[1];
    assign missed_c = missed_q[2];

endmodule

// File: tb/tb_intr_request_source.sv
// tb_intr_request_source
//
// Directed bench for intr_request_source with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "N ticks after a drive" means the value after edge N-1
// counting the first sampling edge as edge 0.

module tb_intr_request_source;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn;
    logic [1:0] clr_no;
    logic       clr_missed;
    logic [2:0] irq;
    logic [7:0] missed_a;
    logic [7:0] missed_b;
    logic [7:0] missed_c;

    int vectors;
    int miscompares;

    intr_request_source #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .clr_no(clr_no),
        .clr_missed(clr_missed),
        .irq(irq),
        .missed_a(missed_a),
        .missed_b(missed_b),
        .missed_c(missed_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        btn        = 3'b000;
        clr_no     = 2'd0;
        clr_missed = 1'b0;
        #12;
        vectors++;
        if (irq !== 3'b000 || missed_a !== 8'd0 || missed_b !== 8'd0 || missed_c !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: irq=%b ma=%0d mb=%0d mc=%0d, required all 0",
                     irq, missed_a, missed_b, missed_c);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_press_latency();
        btn[0] = 1'b1;
        repeat (D + 3) tick();
        vectors++;
        if (irq !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL press_early: irq=%b, required 000", irq);
        end
        tick();
        vectors++;
        if (irq !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL press_latency: irq=%b, required 001", irq);
        end
    endtask

    task automatic test_bounce();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn[1] = 1'b1;
            repeat (3) begin tick(); seen |= irq[1]; end
            btn[1] = 1'b0;
            repeat (3) begin tick(); seen |= irq[1]; end
        end
        repeat (10) begin tick(); seen |= irq[1]; end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bounce_irq: irq_b seen=%b, required 0", seen);
        end
        vectors++;
        if (missed_b !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL bounce_missed: missed_b=%0d, required 0", missed_b);
        end
    endtask

    task automatic test_ack_handshake();
        btn[0] = 1'b0;
        repeat (10) tick();
        clr_no = 2'd1;
        repeat (5) tick();
        vectors++;
        if (irq[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ack_early: irq_a=%b, required 1", irq[0]);
        end
        tick();
        vectors++;
        if (irq[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ack_latency: irq_a=%b, required 0", irq[0]);
        end
        // Press while acknowledged but clear number still held
        btn[0] = 1'b1;
        repeat (D + 3) tick();
        vectors++;
        if (missed_a !== 8'd1 || irq[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ack_missed: missed_a=%0d irq_a=%b, required 1 and 0", missed_a, irq[0]);
        end
        clr_no = 2'd0;
        repeat (8) tick();
        vectors++;
        if (irq[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ack_no_rearm: irq_a=%b, required 0", irq[0]);
        end
        btn[0] = 1'b0;
        repeat (10) tick();
        btn[0] = 1'b1;
        repeat (D + 3) tick();
        vectors++;
        if (irq[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rearm_early: irq_a=%b, required 0", irq[0]);
        end
        tick();
        vectors++;
        if (irq[0] !== 1'b1 || missed_a !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL rearm: irq_a=%b missed_a=%0d, required 1 and 1", irq[0], missed_a);
        end
        btn[0] = 1'b0;
        clr_no = 2'd1;
        repeat (8) tick();
        clr_no = 2'd0;
        repeat (8) tick();
        vectors++;
        if (irq !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL ack_cleanup: irq=%b, required 000", irq);
        end
    endtask

    task automatic test_clr_glitch();
        btn = 3'b110;
        repeat (D + 4) tick();
        vectors++;
        if (irq !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL glitch_setup: irq=%b, required 110", irq);
        end
        clr_no = 2'd1;
        repeat (6) tick();
        clr_no = 2'd2;
        tick();
        clr_no = 2'd3;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (irq[1] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL glitch_hold_b: cycle %0d irq_b=%b, required 1", k, irq[1]);
            end
        end
        vectors++;
        if (irq[2] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL glitch_clear_c: irq_c=%b, required 0", irq[2]);
        end
        btn    = 3'b000;
        clr_no = 2'd2;
        repeat (8) tick();
        vectors++;
        if (irq !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL glitch_cleanup: irq=%b, required 000", irq);
        end
        clr_no = 2'd0;
        repeat (8) tick();
    endtask

    task automatic test_saturate();
        btn[2] = 1'b1;
        repeat (D + 4) tick();
        vectors++;
        if (irq[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sat_setup: irq_c=%b, required 1", irq[2]);
        end
        btn[2] = 1'b0;
        repeat (8) tick();
        for (int p = 0; p < 300; p++) begin
            btn[2] = 1'b1;
            repeat (8) tick();
            btn[2] = 1'b0;
            repeat (8) tick();
            if (p == 9) begin
                vectors++;
                if (missed_c !== 8'd10) begin
                    miscompares++;
                    $display("[TB] FAIL sat_count10: missed_c=%0d, required 10", missed_c);
                end
            end
        end
        vectors++;
        if (missed_c !== 8'd255 || irq[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sat_255: missed_c=%0d irq_c=%b, required 255 and 1", missed_c, irq[2]);
        end
        // clr_missed on the same edge the press would increment
        btn[2] = 1'b1;
        repeat (D + 2) tick();
        clr_missed = 1'b1;
        tick();
        clr_missed = 1'b0;
        vectors++;
        if (missed_c !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL clear_wins: missed_c=%0d, required 0", missed_c);
        end
        btn[2] = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        clr_missed = 1'b1;
        tick();
        clr_missed = 1'b0;
        btn = 3'b011;
        repeat (D + 4) tick();
        btn = 3'b000;
        repeat (8) tick();
        for (int p = 0; p < 9; p++) begin
            btn[0] = 1'b1;
            repeat (8) tick();
            btn[0] = 1'b0;
            repeat (8) tick();
        end
        vectors++;
        if (irq !== 3'b111 || missed_a !== 8'd9) begin
            miscompares++;
            $display("[TB] FAIL areset_setup: irq=%b missed_a=%0d, required 111 and 9", irq, missed_a);
        end
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        btn[0] = 1'b1;
        #1;
        vectors++;
        if (irq !== 3'b000 || missed_a !== 8'd0 || missed_b !== 8'd0 || missed_c !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL areset_immediate: irq=%b ma=%0d mb=%0d mc=%0d, required all 0",
                     irq, missed_a, missed_b, missed_c);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (D + 3) tick();
        vectors++;
        if (irq !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL held_press_early: irq=%b, required 000", irq);
        end
        tick();
        vectors++;
        if (irq !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL held_press: irq=%b, required 001", irq);
        end
    endtask

    // Scenarios run back to back; each leaves the channels it used idle
    // except where the next scenario relies on a pending request.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_press_latency();
        test_bounce();
        test_ack_handshake();
        test_clr_glitch();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
